decoupled_vr_rr_arbiter: RTL and testbench



---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/decoupled_vr_skid.sv | 63 ++++++
 rtl/decoupled_vr_rr_arbiter.sv | 102 ++++++++++
 tb/tb_decoupled_vr_rr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the cohort fifo_ctrl ready/valid arbiter.
// Optional stats build: COHORT_VR_ARB_STATS_EN (see decoupled_vr_rr_arbiter).
package fifo_ctrl_pkg;

    localparam int data_width = 32;
    localparam int max_chan = 16;

    typedef logic [3:0] chan_idx_t;

    function automatic chan_idx_t rr_next(input chan_idx_t p, input int n);
        return (int'(p) + 1 >= n) ? chan_idx_t'(0) : p + chan_idx_t'(1);
    endfunction

endpackage

// File: rtl/decoupled_vr_skid.sv
// Two-entry per-channel skid FIFO with a registered in_ready.
// in_ready is precomputed from the next count so it never depends on inputs.
module decoupled_vr_skid
    import fifo_ctrl_pkg::*;
#(
    parameter int DataWidth = data_width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data
);

    logic [1:0][DataWidth-1:0] mem_q;
    logic                      rd_q;
    logic                      wr_q;
    logic                      rdy_q;
    logic [1:0]                cnt_q;
    logic [1:0]                cnt_d;
    logic                      push;
    logic                      pop;

    assign push = in_valid & rdy_q;
    assign pop  = out_ready & (cnt_q != 2'd0);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            rdy_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d < 2'd2);
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];

endmodule

// File: rtl/decoupled_vr_rr_arbiter.sv
// N-to-1 round-robin ready/valid arbiter with per-channel skids and a registered output.
// Define COHORT_VR_ARB_STATS_EN to add saturating per-channel grant counters.
module decoupled_vr_rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int DataWidth = data_width,
    parameter  int NumChan   = 4,
    localparam int ChanW     = $clog2(NumChan)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NumChan-1:0]                in_valid,
    output logic [NumChan-1:0]                in_ready,
    input  logic [NumChan-1:0][DataWidth-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DataWidth-1:0]              out_data,
    output logic [ChanW-1:0]                  out_chan
`ifdef COHORT_VR_ARB_STATS_EN
    ,
    output logic [NumChan-1:0][31:0]          grant_cnt
`endif
);

    logic [NumChan-1:0]                skid_vld;
    logic [NumChan-1:0]                skid_pop;
    logic [NumChan-1:0][DataWidth-1:0] skid_data;
    logic [ChanW-1:0]                  ptr_q;
    logic [ChanW-1:0]                  win;
    logic [ChanW-1:0]                  cand;
    logic                              found;
    logic                              load;

    for (genvar g = 0; g < NumChan; g++) begin : g_skid
        decoupled_vr_skid #(
            .DataWidth(DataWidth)
        ) u_skid (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(skid_vld[g]),
            .out_ready(skid_pop[g]),
            .out_data (skid_data[g])
        );
        assign skid_pop[g] = load && (win == ChanW'(g));
    end

    // First non-empty skid scanning upward from the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < NumChan; i++) begin
            cand = ChanW'((int'(ptr_q) + i) % NumChan);
            if (!found && skid_vld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign load = found && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            ptr_q     <= ChanW'(rr_next(4'(win), NumChan));
            out_valid <= 1'b1;
            out_data  <= skid_data[win];
            out_chan  <= win;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef COHORT_VR_ARB_STATS_EN
    logic [NumChan-1:0][31:0] grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
        end else begin
            for (int i = 0; i < NumChan; i++) begin
                if (skid_pop[i] && (grant_q[i] != 32'hFFFF_FFFF)) begin
                    grant_q[i] <= grant_q[i] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt = grant_q;
`else
    // Stats build off: no counters, datapath unchanged.
`endif

endmodule

// File: tb/tb_decoupled_vr_rr_arbiter.sv
// Randomised and directed bench for decoupled_vr_rr_arbiter.
// Scoreboard: per-channel queues of accepted beats; outputs must pop them in order.
module tb_decoupled_vr_rr_arbiter;
    import fifo_ctrl_pkg::*;

    localparam int N = 4;
    localparam int W = data_width;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N-1:0][W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [1:0]          out_chan;
`ifdef COHORT_VR_ARB_STATS_EN
    logic [N-1:0][31:0]  grant_cnt;
`endif

    decoupled_vr_rr_arbiter #(
        .DataWidth(W),
        .NumChan  (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_chan (out_chan)
`ifdef COHORT_VR_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] mq[N][$];
    int fire_chan[$];
    int acc_ch[N];
    int acc_cnt;
    int fire_cnt;
    logic pv;
    logic pr;
    logic [W-1:0] pd;
    logic [1:0] pc;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            acc_ch[i] = 0;
        end
        fire_chan.delete();
        acc_cnt = 0;
        fire_cnt = 0;
        pv = 1'b0;
        pr = 1'b0;
    endtask

    // One cycle: check held output, drive, then record handshakes for the next edge.
    task automatic cycle(input logic [N-1:0] v, input logic r,
                         input logic [N-1:0][W-1:0] d);
        @(negedge clk);
        if (pv && !pr) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== pd || out_chan !== pc) begin
                bad++;
                $display("FAIL hold: valid=%b data=%h chan=%0d, need valid=1 data=%h chan=%0d",
                         out_valid, out_data, out_chan, pd, pc);
            end
        end
        in_valid = v;
        out_ready = r;
        in_data = d;
        #1;
        if (out_valid && out_ready) begin
            total++;
            if (mq[out_chan].size() == 0) begin
                bad++;
                $display("FAIL extra_beat: chan=%0d data=%h, need no beat", out_chan, out_data);
            end else begin
                if (out_data !== mq[out_chan][0]) begin
                    bad++;
                    $display("FAIL order: chan=%0d data=%h, need %h",
                             out_chan, out_data, mq[out_chan][0]);
                end
                void'(mq[out_chan].pop_front());
            end
            fire_chan.push_back(int'(out_chan));
            fire_cnt++;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && in_ready[i]) begin
                mq[i].push_back(d[i]);
                acc_ch[i]++;
                acc_cnt++;
            end
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        pc = out_chan;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0][W-1:0] tags();
        logic [N-1:0][W-1:0] d;
        for (int i = 0; i < N; i++) begin
            d[i] = W'(32'hA000_0000 | (i << 16) | acc_ch[i]);
        end
        return d;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, 1'b1, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '1;
        out_ready = 1'b0;
        in_data = '0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (in_ready !== '0 || out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== '0) begin
                bad++;
                $display("FAIL reset_hold: in_ready=%b valid=%b chan=%0d data=%h, need 0",
                         in_ready, out_valid, out_chan, out_data);
            end
        end
        rst_n = 1'b1;
        in_valid = '0;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b1111) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b, need 1111", in_ready);
        end
    endtask

    task automatic test_single_stream();
        logic [N-1:0][W-1:0] d;
        do_reset();
        for (int j = 0; j < 10; j++) begin
            d = '0;
            d[2] = W'(32'h10 + j);
            cycle((j < 8) ? 4'b0100 : 4'b0000, 1'b1, d);
            total++;
            if (j < 2) begin
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL single_early: cycle %0d valid=%b, need 0", j, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_data !== W'(32'h10 + j - 2) || out_chan !== 2'd2) begin
                bad++;
                $display("FAIL single_beat: cycle %0d valid=%b data=%h chan=%0d, need 1 %h 2",
                         j, out_valid, out_data, out_chan, 32'h10 + j - 2);
            end
            if (j < 8) begin
                total++;
                if (in_ready[2] !== 1'b1) begin
                    bad++;
                    $display("FAIL single_ready: cycle %0d in_ready=%b, need 1", j, in_ready[2]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 16; k++) cycle('1, 1'b1, tags());
        idle(12);
        total++;
        if (fire_chan.size() < 8) begin
            bad++;
            $display("FAIL rr_count: grants=%0d, need >=8", fire_chan.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (fire_chan[k] != k % N) begin
                    bad++;
                    $display("FAIL rr_seq: grant %0d chan=%0d, need %0d", k, fire_chan[k], k % N);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 10; k++) cycle('1, 1'b0, tags());
        total++;
        if (acc_cnt != 9) begin
            bad++;
            $display("FAIL bp_accepted: beats=%0d, need 9", acc_cnt);
        end
        total++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== W'(32'hA000_0000)) begin
            bad++;
            $display("FAIL bp_full: in_ready=%b valid=%b data=%h, need 0000 1 a0000000",
                     in_ready, out_valid, out_data);
        end
        fire_cnt = 0;
        idle(12);
        total++;
        if (fire_cnt != 9) begin
            bad++;
            $display("FAIL bp_drain: beats=%0d, need 9", fire_cnt);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (mq[i].size() != 0) begin
                bad++;
                $display("FAIL bp_left: chan=%0d left=%0d, need 0", i, mq[i].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(4'b0011, 1'b0, tags());
        cycle('0, 1'b0, '0);
        total++;
        if (acc_cnt != 5 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup: beats=%0d valid=%b, need 5 1", acc_cnt, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            bad++;
            $display("FAIL mid_async: valid=%b in_ready=%b, need 0 0000", out_valid, in_ready);
        end
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle('0, 1'b1, '0);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale: cycle %0d valid=%b, need 0", k, out_valid);
            end
        end
        fire_chan.delete();
        cycle('1, 1'b1, tags());
        idle(8);
        total++;
        if (fire_chan.size() != 4 || fire_chan[0] != 0) begin
            bad++;
            $display("FAIL mid_ptr: grants=%0d first=%0d, need 4 0",
                     fire_chan.size(), (fire_chan.size() > 0) ? fire_chan[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0][W-1:0] d;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) d[i] = W'($urandom);
            cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), d);
        end
        idle(30);
        for (int i = 0; i < N; i++) begin
            total++;
            if (mq[i].size() != 0) begin
                bad++;
                $display("FAIL rand_left: chan=%0d left=%0d, need 0", i, mq[i].size());
            end
        end
    endtask

`ifdef COHORT_VR_ARB_STATS_EN
    task automatic test_stats();
        logic [N-1:0] v;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) v[i] = (acc_ch[i] < 3);
            cycle(v, 1'b1, tags());
        end
        idle(10);
        for (int i = 0; i < N; i++) begin
            total++;
            if (grant_cnt[i] !== 32'd3) begin
                bad++;
                $display("FAIL stats_cnt: chan=%0d cnt=%0d, need 3", i, grant_cnt[i]);
            end
        end
        dut.grant_q[0] = 32'hFFFF_FFFE;
        acc_ch[0] = 0;
        for (int k = 0; k < 6; k++) begin
            v = '0;
            v[0] = (acc_ch[0] < 3);
            cycle(v, 1'b1, tags());
        end
        idle(6);
        total++;
        if (grant_cnt[0] !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL stats_sat: cnt=%h, need ffffffff", grant_cnt[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef COHORT_VR_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
